// File: rtl/clk_period_monitor_if.sv
// -----------------------------------------------------------------------------
// clk_period_monitor_if
//
// Purpose:
//   Groups the result signals of clk_period_monitor into one bundle, so that
//   downstream logic can take the edge ticks and the period status through a
//   single port.
//
// Parameters:
//   CNT_W           width of periodOut; must match the monitor's CNT_W
//
// Signals (all synchronous to the monitor's clkIn):
//   riseOut         one-cycle tick per detected rising edge of the signal
//   fallOut         one-cycle tick per detected falling edge of the signal
//   periodOut       last measured rising-to-rising period, in clkIn cycles
//   periodValidOut  one-cycle pulse when periodOut updates
//   stableOut       the last two measured periods were equal
//   lostOut         high while the monitored signal is considered lost
//
// Modports:
//   master          the monitor, which drives every signal
//   slave           a consumer, which reads every signal
// -----------------------------------------------------------------------------
interface clk_period_monitor_if #(
    parameter int CNT_W = 16
);

    logic             riseOut;
    logic             fallOut;
    logic [CNT_W-1:0] periodOut;
    logic             periodValidOut;
    logic             stableOut;
    logic             lostOut;

    modport master (
        output riseOut,
        output fallOut,
        output periodOut,
        output periodValidOut,
        output stableOut,
        output lostOut
    );

    modport slave (
        input  riseOut,
        input  fallOut,
        input  periodOut,
        input  periodValidOut,
        input  stableOut,
        input  lostOut
    );

endinterface : clk_period_monitor_if

// File: rtl/clk_period_monitor.sv
// -----------------------------------------------------------------------------
// clk_period_monitor
//
// Purpose:
//   Watches a slow periodic signal (typically the output of the clock
//   divider) from inside the fast clkIn domain. The signal is sampled, turned
//   into one-cycle rise/fall ticks that downstream logic uses as clock
//   enables, and its rising-edge period is measured in clkIn cycles. The
//   block also reports when two consecutive periods match and when no rising
//   edge has arrived for TIMEOUT cycles.
//
// Configuration macro:
//   CLK_MON_SYNC_EN  defined     : sigIn passes through a two-flop
//                                  synchronizer; use for asynchronous inputs.
//                    not defined : sigIn is sampled by one register; use only
//                                  for signals generated in the clkIn domain.
//                                  Edge latency is one cycle shorter.
//
// Parameters:
//   CNT_W    width of the period counter and periodOut
//   TIMEOUT  clkIn cycles without a rising edge before loss is declared;
//            legal range 2 .. 2**CNT_W-1
//
// Ports:
//   clkIn    single clock, all logic on its rising edge
//   rstIn    synchronous, active-high reset
//   enIn     block enable; low forces the FSM to IDLE and gates the ticks
//   sigIn    monitored signal
//   mon      result bundle (master side): riseOut, fallOut, periodOut,
//            periodValidOut, stableOut, lostOut
//
// Latency (counted from the first clkIn edge that samples a new sigIn level):
//   riseOut/fallOut are high in the cycle after the 3rd edge with the
//   synchronizer and after the 2nd edge without it. periodOut,
//   periodValidOut and stableOut update in the same cycle as riseOut.
// -----------------------------------------------------------------------------
module clk_period_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 enIn,
    input  logic                 sigIn,
    clk_period_monitor_if.master mon
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        LOST       = 2'd3
    } stateT;

    // What the period counter does on the next edge.
    typedef enum logic [1:0] {
        CNT_HOLD  = 2'd0,
        CNT_CLEAR = 2'd1,
        CNT_LOAD1 = 2'd2,
        CNT_INC   = 2'd3
    } cntOpT;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Input path: sample stage(s) feeding s, then the history register h.
    // These run whenever reset is low, independent of enIn, so enabling the
    // block while sigIn is steady cannot fabricate an edge.
    // -------------------------------------------------------------------------
    logic sampleS;   // s: last sample stage
    logic histQ;     // h: previous value of s

`ifdef CLK_MON_SYNC_EN
    logic sync1Q;
    logic sync2Q;

    always_ff @(posedge clkIn) begin
        // NOTE: sequential state is always written with non-blocking
        // assignments so every flop samples the pre-edge value of its source;
        // with blocking '=' sync2Q would copy sigIn in a single edge and the
        // synchronizer would collapse to one stage.
        if (rstIn) begin
            sync1Q <= 1'b0;
            sync2Q <= 1'b0;
        end else begin
            sync1Q <= sigIn;
            sync2Q <= sync1Q;
        end
    end

    assign sampleS = sync2Q;
`else
    logic sampleQ;

    always_ff @(posedge clkIn) begin
        // NOTE: sequential state is always written with non-blocking
        // assignments so every flop samples the pre-edge value of its source,
        // regardless of the order the blocks are evaluated in.
        if (rstIn) begin
            sampleQ <= 1'b0;
        end else begin
            sampleQ <= sigIn;
        end
    end

    assign sampleS = sampleQ;
`endif

    // The history register is cleared by reset, so a sigIn that is already
    // high at reset release yields exactly one rise after the normal latency.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            histQ <= 1'b0;
        end else begin
            histQ <= sampleS;
        end
    end

    logic riseC;
    logic fallC;
    logic riseEv;    // rise as seen by the FSM (already gated by enIn)
    logic fallEv;

    assign riseC  = sampleS & ~histQ;
    assign fallC  = ~sampleS & histQ;
    assign riseEv = riseC & enIn;
    assign fallEv = fallC & enIn;

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    stateT            stateQ;
    stateT            stateNext;
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] periodQ;
    logic             periodValidQ;
    logic             stableQ;
    logic             havePeriodQ;   // a period was reported since MEASURE entry
    logic             riseQ;
    logic             fallQ;

    logic             cntAtLimit;

    // The counter stops at TIMEOUT (the FSM leaves for LOST or reloads on a
    // rise), so it never wraps and TIMEOUT itself is a reportable period.
    assign cntAtLimit = (cntQ == TIMEOUT_C);

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // A rise in the same cycle as cntAtLimit wins, so a period of exactly
    // TIMEOUT is reported instead of being treated as loss.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first; any path that leaves it unassigned would otherwise
        // infer a latch.
        stateNext = stateQ;

        if (!enIn) begin
            stateNext = IDLE;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    stateNext = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (riseEv) begin
                        stateNext = MEASURE;
                    end else if (cntAtLimit) begin
                        stateNext = LOST;
                    end
                end
                MEASURE: begin
                    if (!riseEv && cntAtLimit) begin
                        stateNext = LOST;
                    end
                end
                LOST: begin
                    if (riseEv) begin
                        stateNext = MEASURE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output / datapath-control logic
    //   cntOp         counter action for this edge
    //   reportPeriod  capture cntQ into periodOut and pulse periodValidOut
    //   enterMeasure  MEASURE is entered from WAIT_FIRST or LOST
    //   clearStable   entering LOST or IDLE
    // -------------------------------------------------------------------------
    cntOpT cntOp;
    logic  reportPeriod;
    logic  enterMeasure;
    logic  clearStable;

    always_comb begin
        cntOp        = CNT_HOLD;
        reportPeriod = 1'b0;
        enterMeasure = 1'b0;
        clearStable  = 1'b0;

        if (!enIn) begin
            cntOp       = CNT_CLEAR;
            clearStable = 1'b1;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    cntOp = CNT_CLEAR;
                end
                WAIT_FIRST: begin
                    if (riseEv) begin
                        cntOp        = CNT_LOAD1;
                        enterMeasure = 1'b1;
                    end else if (cntAtLimit) begin
                        clearStable = 1'b1;
                    end else begin
                        cntOp = CNT_INC;
                    end
                end
                MEASURE: begin
                    if (riseEv) begin
                        cntOp        = CNT_LOAD1;
                        reportPeriod = 1'b1;
                    end else if (cntAtLimit) begin
                        clearStable = 1'b1;
                    end else begin
                        cntOp = CNT_INC;
                    end
                end
                LOST: begin
                    // The edge that ends LOST restarts measurement but carries
                    // no period: the gap before it is unknown.
                    if (riseEv) begin
                        cntOp        = CNT_LOAD1;
                        enterMeasure = 1'b1;
                    end
                end
                default: begin
                    cntOp = CNT_CLEAR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Counter, period capture, stability flag and edge ticks
    // -------------------------------------------------------------------------
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cntQ         <= '0;
            periodQ      <= '0;
            periodValidQ <= 1'b0;
            stableQ      <= 1'b0;
            havePeriodQ  <= 1'b0;
            riseQ        <= 1'b0;
            fallQ        <= 1'b0;
        end else begin
            riseQ        <= riseEv;
            fallQ        <= fallEv;
            periodValidQ <= reportPeriod;

            unique case (cntOp)
                CNT_CLEAR: cntQ <= '0;
                CNT_LOAD1: cntQ <= ONE_C;
                CNT_INC:   cntQ <= cntQ + ONE_C;
                default:   cntQ <= cntQ;
            endcase

            if (reportPeriod) begin
                periodQ     <= cntQ;
                // Only a period measured in the same MEASURE run may be used
                // as the reference; an older periodOut may be stale.
                stableQ     <= havePeriodQ && (cntQ == periodQ);
                havePeriodQ <= 1'b1;
            end else if (clearStable) begin
                stableQ <= 1'b0;
            end

            if (enterMeasure) begin
                havePeriodQ <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result bundle
    // -------------------------------------------------------------------------
    assign mon.riseOut        = riseQ;
    assign mon.fallOut        = fallQ;
    assign mon.periodOut      = periodQ;
    assign mon.periodValidOut = periodValidQ;
    assign mon.stableOut      = stableQ;
    assign mon.lostOut        = (stateQ == LOST);

endmodule : clk_period_monitor

// File: tb/tb_clk_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_clk_period_monitor
//
// Purpose:
//   Self-checking bench for clk_period_monitor (TIMEOUT = 20). Stimulus tasks
//   drive sigIn/enIn and push the expected tick, period, loss and stability
//   events (with the cycle they are due in) into per-kind queues. A monitor
//   process pops and compares whenever the DUT shows one of those events; an
//   event with nothing queued for it is a failure, and every queue must be
//   empty at the end. Works with and without CLK_MON_SYNC_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_period_monitor;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;
`ifdef CLK_MON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int cyc;
        int period;
        bit stable;
    } periodExpT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic sig = 1'b0;

    int cyc         = 0;
    int nChecks     = 0;
    int nFail       = 0;
    int lastEdgeCyc = 0;

    int        riseQ[$];
    int        fallQ[$];
    int        lostOnQ[$];
    int        lostOffQ[$];
    int        stableOffQ[$];
    periodExpT periodQ[$];
    periodExpT monExp;

    logic prevLost   = 1'b0;
    logic prevStable = 1'b0;

    clk_period_monitor_if #(.CNT_W(CNT_W)) mon ();

    clk_period_monitor #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clkIn (clk),
        .rstIn (rst),
        .enIn  (en),
        .sigIn (sig),
        .mon   (mon)
    );

    always #5 clk = ~clk;

    // Number of rising clk edges so far; read on falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: pops and compares on every DUT event
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon.lostOut && !prevLost) begin
            if (lostOnQ.size() == 0) check("lost_on_unexpected", cyc, -1);
            else                     check("lost_on_cycle", cyc, lostOnQ.pop_front());
        end
        if (!mon.lostOut && prevLost) begin
            if (lostOffQ.size() == 0) check("lost_off_unexpected", cyc, -1);
            else                      check("lost_off_cycle", cyc, lostOffQ.pop_front());
        end
        if (mon.riseOut) begin
            if (riseQ.size() == 0) check("rise_unexpected", cyc, -1);
            else                   check("rise_cycle", cyc, riseQ.pop_front());
        end
        if (mon.fallOut) begin
            if (fallQ.size() == 0) check("fall_unexpected", cyc, -1);
            else                   check("fall_cycle", cyc, fallQ.pop_front());
        end
        if (mon.periodValidOut) begin
            if (periodQ.size() == 0) begin
                check("period_unexpected", cyc, -1);
            end else begin
                monExp = periodQ.pop_front();
                check("period_cycle", cyc, monExp.cyc);
                check("period_value", mon.periodOut, monExp.period);
                check("period_stable", mon.stableOut, monExp.stable);
            end
        end else if (mon.stableOut != prevStable) begin
            if (mon.stableOut) begin
                check("stable_set_without_period", mon.stableOut, 0);
            end else if (stableOffQ.size() == 0) begin
                check("stable_off_unexpected", cyc, -1);
            end else begin
                check("stable_off_cycle", cyc, stableOffQ.pop_front());
            end
        end
        prevLost   = mon.lostOut;
        prevStable = mon.stableOut;
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (called on falling edges)
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new sigIn level and expect the matching tick LAT cycles later.
    task automatic setSig(input logic level);
        sig         = level;
        lastEdgeCyc = cyc + LAT;
        if (level) riseQ.push_back(lastEdgeCyc);
        else       fallQ.push_back(lastEdgeCyc);
    endtask

    task automatic pushPeriod(input int period, input bit stable);
        periodExpT e;
        e.cyc    = lastEdgeCyc;
        e.period = period;
        e.stable = stable;
        periodQ.push_back(e);
    endtask

    // One high/low pulse; the rise reports the gap since the previous rise.
    task automatic pulse(input int hi, input int lo, input bit hasPeriod,
                         input int period, input bit stable);
        setSig(1'b1);
        if (hasPeriod) pushPeriod(period, stable);
        tick(hi);
        setSig(1'b0);
        tick(lo);
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sig = 1'b0;
        tick(3);
        check("reset_rise",   mon.riseOut, 0);
        check("reset_fall",   mon.fallOut, 0);
        check("reset_period", mon.periodOut, 0);
        check("reset_valid",  mon.periodValidOut, 0);
        check("reset_stable", mon.stableOut, 0);
        check("reset_lost",   mon.lostOut, 0);

        rst = 1'b0;
        en  = 1'b1;
        tick(2);

        // Period 8: first rise enters MEASURE, stable from the second report.
        pulse(4, 4, 1'b0, 0, 1'b0);
        pulse(4, 4, 1'b1, 8, 1'b0);
        pulse(4, 4, 1'b1, 8, 1'b1);
        pulse(4, 4, 1'b1, 8, 1'b1);
        pulse(4, 4, 1'b1, 8, 1'b1);
        // Period changes to 10: one unstable report, then stable again.
        pulse(5, 5, 1'b1, 8, 1'b1);
        pulse(5, 5, 1'b1, 10, 1'b0);

        // Reports 10 (stable), then sigIn stays low: after 20 counted cycles
        // the block goes LOST and drops stableOut in the same cycle.
        setSig(1'b1);
        pushPeriod(10, 1'b1);
        lostOnQ.push_back(lastEdgeCyc + 20);
        stableOffQ.push_back(lastEdgeCyc + 20);
        tick(4);
        setSig(1'b0);
        tick(26);

        // The next rise leaves LOST without a report; the one after reports 8.
        lostOffQ.push_back(cyc + LAT);
        pulse(4, 4, 1'b0, 0, 1'b0);
        pulse(4, 4, 1'b1, 8, 1'b0);
        pulse(10, 10, 1'b1, 8, 1'b1);
        // Period exactly TIMEOUT: the rise wins, no loss.
        pulse(10, 10, 1'b1, 20, 1'b0);

        // Drop enIn mid-measurement with sigIn high, re-enable while still high.
        setSig(1'b1);
        pushPeriod(20, 1'b1);
        tick(6);
        en = 1'b0;
        stableOffQ.push_back(cyc + 1);
        tick(3);
        check("disabled_stable", mon.stableOut, 0);
        check("disabled_lost",   mon.lostOut, 0);
        en = 1'b1;
        tick(6);
        setSig(1'b0);
        tick(4);
        pulse(4, 4, 1'b0, 0, 1'b0);
        setSig(1'b1);
        pushPeriod(8, 1'b0);
        tick(4);
        setSig(1'b0);
        tick(6);
        en = 1'b0;
        tick(4);

        // Reset with sigIn high: exactly one rise after release.
        rst = 1'b1;
        sig = 1'b1;
        tick(3);
        check("rereset_period", mon.periodOut, 0);
        check("rereset_stable", mon.stableOut, 0);
        check("rereset_rise",   mon.riseOut, 0);
        rst = 1'b0;
        en  = 1'b1;
        riseQ.push_back(cyc + LAT);
        tick(8);

        check("left_rise",       riseQ.size(), 0);
        check("left_fall",       fallQ.size(), 0);
        check("left_period",     periodQ.size(), 0);
        check("left_lost_on",    lostOnQ.size(), 0);
        check("left_lost_off",   lostOffQ.size(), 0);
        check("left_stable_off", stableOffQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_clk_period_monitor
